// File: rtl/ext_tid_alloc.sv
`default_nettype none
// ============================================================================
// Module      : ext_tid_alloc
// Description : Transaction-ID allocator for the MCHAN external interface.
//               Grants a free EXT TID per outgoing request (0-cycle grant),
//               drives the opcode-buffer write strobe/index, frees TIDs on
//               the last response beat, counts outstanding transactions and
//               flags releases of TIDs that are not busy (sticky error).
//               Optional feature macro: EXT_TID_ROUND_ROBIN_EN
//                 undefined : candidate is the lowest-index free TID
//                 defined   : candidate is the first free TID at or above a
//                             round-robin pointer, wrapping around the pool
// Revision    : 1.0 - initial release
// ============================================================================
module ext_tid_alloc #(
    parameter int EXT_TID_WIDTH   = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     alloc_req_i,
    output logic                     alloc_gnt_o,
    output logic                     tid_valid_o,
    output logic [EXT_TID_WIDTH-1:0] tid_o,
    input  logic                     rel_valid_i,
    input  logic [EXT_TID_WIDTH-1:0] rel_tid_i,
    output logic [EXT_TID_WIDTH:0]   outst_cnt_o,
    output logic                     full_o,
    output logic                     idle_o,
    output logic                     err_o
);

    localparam int                   c_POOL_SIZE = 1 << EXT_TID_WIDTH;
    localparam logic [EXT_TID_WIDTH:0] c_MAX_CNT = (EXT_TID_WIDTH + 1)'(MAX_OUTSTANDING);

    // Reject configurations where the outstanding limit cannot be reached
    // or exceeds the pool; the counter relies on this range.
    generate
        if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > c_POOL_SIZE)) begin : g_param_check
            $error("ext_tid_alloc: MAX_OUTSTANDING out of range");
        end
    endgenerate

    logic [c_POOL_SIZE-1:0]   r_busy;
    logic [EXT_TID_WIDTH:0]   r_cnt;
    logic                     r_err;

    logic [EXT_TID_WIDTH-1:0] w_cand;
    logic                     w_any_free;
    logic                     w_gnt;
    logic                     w_rel_ok;
    logic                     w_rel_bad;
    logic [c_POOL_SIZE-1:0]   w_set_vec;
    logic [c_POOL_SIZE-1:0]   w_clr_vec;

`ifdef EXT_TID_ROUND_ROBIN_EN
    logic [EXT_TID_WIDTH-1:0] r_rr_ptr;
    logic [EXT_TID_WIDTH-1:0] w_rr_idx;

    // Candidate search: first free TID starting at the pointer, wrapping
    always_comb begin
        w_cand     = '0;
        w_any_free = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < c_POOL_SIZE; k++) begin
            w_rr_idx = r_rr_ptr + EXT_TID_WIDTH'(k);
            if (!w_any_free && !r_busy[w_rr_idx]) begin
                w_cand     = w_rr_idx;
                w_any_free = 1'b1;
            end
        end
    end

    // Move the pointer just past each granted TID so reuse is spread out
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_gnt) begin
            r_rr_ptr <= w_cand + EXT_TID_WIDTH'(1);
        end
    end
`else
    // Candidate search: lowest-index free TID (scan top-down, last hit wins)
    always_comb begin
        w_cand     = '0;
        w_any_free = 1'b0;
        for (int i = c_POOL_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_cand     = EXT_TID_WIDTH'(i);
                w_any_free = 1'b1;
            end
        end
    end
`endif

    // Grant is purely combinational from the request and registered state;
    // the candidate never sees a same-cycle release.
    assign full_o      = (r_cnt == c_MAX_CNT);
    assign idle_o      = (r_cnt == '0);
    assign w_gnt       = alloc_req_i & ~full_o & w_any_free;
    assign alloc_gnt_o = w_gnt;
    assign tid_valid_o = alloc_req_i & w_gnt;
    assign tid_o       = w_cand;
    assign outst_cnt_o = r_cnt;
    assign err_o       = r_err;

    // A release is only honoured for a TID that is currently busy
    assign w_rel_ok  = rel_valid_i &  r_busy[rel_tid_i];
    assign w_rel_bad = rel_valid_i & ~r_busy[rel_tid_i];

    // One-hot set/clear masks for the busy vector
    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (tid_valid_o) begin
            w_set_vec[w_cand] = 1'b1;
        end
        if (w_rel_ok) begin
            w_clr_vec[rel_tid_i] = 1'b1;
        end
    end

    // Busy vector: mark granted TID, free the released one (never the same TID)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy | w_set_vec) & ~w_clr_vec;
        end
    end

    // Outstanding counter: grant and valid release in the same cycle cancel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else begin
            case ({w_gnt, w_rel_ok})
                2'b10:   r_cnt <= r_cnt + (EXT_TID_WIDTH + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (EXT_TID_WIDTH + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky protocol error: set on release of a non-busy TID, cleared by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_rel_bad) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_tid_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_tid_alloc
// Description : Directed self-checking bench for ext_tid_alloc. Drives inputs
//               on the falling edge, checks one time unit later. A second
//               instance with MAX_OUTSTANDING=4 covers the reduced limit.
//               EXT_TID_ROUND_ROBIN_EN selects the round-robin expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_tid_alloc;

    logic       clk;
    logic       rst_n;

    logic       alloc_req, alloc_gnt, tid_valid, rel_valid, full, idle, err;
    logic [3:0] tid, rel_tid;
    logic [4:0] outst_cnt;

    logic       alloc_req4, alloc_gnt4, tid_valid4, rel_valid4, full4, idle4, err4;
    logic [3:0] tid4, rel_tid4;
    logic [4:0] outst_cnt4;

    int errors = 0;
    int checks = 0;

`ifdef EXT_TID_ROUND_ROBIN_EN
    localparam int c_EXP_AFTER_SAME_CYCLE = 4;
`else
    localparam int c_EXP_AFTER_SAME_CYCLE = 2;
`endif

    ext_tid_alloc #(.EXT_TID_WIDTH(4), .MAX_OUTSTANDING(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_req_i(alloc_req), .alloc_gnt_o(alloc_gnt), .tid_valid_o(tid_valid), .tid_o(tid),
        .rel_valid_i(rel_valid), .rel_tid_i(rel_tid),
        .outst_cnt_o(outst_cnt), .full_o(full), .idle_o(idle), .err_o(err)
    );

    ext_tid_alloc #(.EXT_TID_WIDTH(4), .MAX_OUTSTANDING(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .alloc_req_i(alloc_req4), .alloc_gnt_o(alloc_gnt4), .tid_valid_o(tid_valid4), .tid_o(tid4),
        .rel_valid_i(rel_valid4), .rel_tid_i(rel_tid4),
        .outst_cnt_o(outst_cnt4), .full_o(full4), .idle_o(idle4), .err_o(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; alloc_req = 1'b0; rel_valid = 1'b0; rel_tid = '0;
        alloc_req4 = 1'b0; rel_valid4 = 1'b0; rel_tid4 = '0;
        @(negedge clk); @(negedge clk);
        alloc_req = 1'b1;
        #1;
        checks++; if (outst_cnt !== 5'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", outst_cnt); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (idle !== 1'b1)      begin errors++; $display("FAIL rst_idle got=%b exp=1", idle); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (tid !== 4'd0)       begin errors++; $display("FAIL rst_tid got=%0d exp=0", tid); end
        checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt got=%b exp=1", alloc_gnt); end
        checks++; if (tid_valid !== 1'b1) begin errors++; $display("FAIL rst_tvalid got=%b exp=1", tid_valid); end
        @(negedge clk);
        alloc_req = 1'b0;
        #1;
        checks++; if (outst_cnt !== 5'd0) begin errors++; $display("FAIL rst_hold_cnt got=%0d exp=0", outst_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_rel_idle got=%b exp=1", idle); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            alloc_req = 1'b1;
            #1;
            checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL fill_gnt[%0d] got=%b exp=1", i, alloc_gnt); end
            checks++; if (tid_valid !== 1'b1) begin errors++; $display("FAIL fill_tvalid[%0d] got=%b exp=1", i, tid_valid); end
            checks++; if (tid !== 4'(i))      begin errors++; $display("FAIL fill_tid[%0d] got=%0d exp=%0d", i, tid, i); end
            checks++; if (outst_cnt !== 5'(i)) begin errors++; $display("FAIL fill_cnt[%0d] got=%0d exp=%0d", i, outst_cnt, i); end
        end
        @(negedge clk);
        #1;
        checks++; if (outst_cnt !== 5'd16) begin errors++; $display("FAIL full_cnt got=%0d exp=16", outst_cnt); end
        checks++; if (full !== 1'b1)       begin errors++; $display("FAIL full_flag got=%b exp=1", full); end
        checks++; if (alloc_gnt !== 1'b0)  begin errors++; $display("FAIL full_gnt got=%b exp=0", alloc_gnt); end
        checks++; if (tid_valid !== 1'b0)  begin errors++; $display("FAIL full_tvalid got=%b exp=0", tid_valid); end
        checks++; if (idle !== 1'b0)       begin errors++; $display("FAIL full_idle got=%b exp=0", idle); end
        @(negedge clk);
        #1;
        checks++; if (outst_cnt !== 5'd16) begin errors++; $display("FAIL full_hold_cnt got=%0d exp=16", outst_cnt); end
        alloc_req = 1'b0;
    endtask

    task automatic test_release_from_full();
        @(negedge clk);
        rel_valid = 1'b1; rel_tid = 4'd5;
        #1;
        checks++; if (outst_cnt !== 5'd16) begin errors++; $display("FAIL rel5_cnt0 got=%0d exp=16", outst_cnt); end
        @(negedge clk);
        rel_valid = 1'b0; alloc_req = 1'b1;
        #1;
        checks++; if (outst_cnt !== 5'd15) begin errors++; $display("FAIL rel5_cnt1 got=%0d exp=15", outst_cnt); end
        checks++; if (full !== 1'b0)       begin errors++; $display("FAIL rel5_full got=%b exp=0", full); end
        checks++; if (alloc_gnt !== 1'b1)  begin errors++; $display("FAIL rel5_gnt got=%b exp=1", alloc_gnt); end
        checks++; if (tid !== 4'd5)        begin errors++; $display("FAIL rel5_tid got=%0d exp=5", tid); end
        @(negedge clk);
        alloc_req = 1'b0;
        #1;
        checks++; if (outst_cnt !== 5'd16) begin errors++; $display("FAIL rel5_cnt2 got=%0d exp=16", outst_cnt); end
        checks++; if (full !== 1'b1)       begin errors++; $display("FAIL rel5_full2 got=%b exp=1", full); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rel5_err got=%b exp=0", err); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (outst_cnt !== 5'd0) begin errors++; $display("FAIL mrst_cnt got=%0d exp=0", outst_cnt); end
        checks++; if (idle !== 1'b1)      begin errors++; $display("FAIL mrst_idle got=%b exp=1", idle); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL mrst_full got=%b exp=0", full); end
        checks++; if (tid !== 4'd0)       begin errors++; $display("FAIL mrst_tid got=%0d exp=0", tid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_same_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alloc_req = 1'b1;
            #1;
            checks++; if (tid !== 4'(i)) begin errors++; $display("FAIL sc_pre_tid[%0d] got=%0d exp=%0d", i, tid, i); end
        end
        @(negedge clk);
        alloc_req = 1'b1; rel_valid = 1'b1; rel_tid = 4'd2;
        #1;
        checks++; if (outst_cnt !== 5'd3) begin errors++; $display("FAIL sc_cnt0 got=%0d exp=3", outst_cnt); end
        checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL sc_gnt got=%b exp=1", alloc_gnt); end
        checks++; if (tid !== 4'd3)       begin errors++; $display("FAIL sc_tid got=%0d exp=3", tid); end
        @(negedge clk);
        rel_valid = 1'b0; alloc_req = 1'b1;
        #1;
        checks++; if (outst_cnt !== 5'd3) begin errors++; $display("FAIL sc_cnt1 got=%0d exp=3", outst_cnt); end
        checks++; if (tid !== 4'(c_EXP_AFTER_SAME_CYCLE)) begin errors++; $display("FAIL sc_next_tid got=%0d exp=%0d", tid, c_EXP_AFTER_SAME_CYCLE); end
        @(negedge clk);
        alloc_req = 1'b0;
        #1;
        checks++; if (outst_cnt !== 5'd4) begin errors++; $display("FAIL sc_cnt2 got=%0d exp=4", outst_cnt); end
    endtask

    task automatic test_err();
        @(negedge clk);
        rel_valid = 1'b1; rel_tid = 4'd9;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before got=%b exp=0", err); end
        @(negedge clk);
        rel_valid = 1'b0;
        #1;
        checks++; if (err !== 1'b1)       begin errors++; $display("FAIL err_set got=%b exp=1", err); end
        checks++; if (outst_cnt !== 5'd4) begin errors++; $display("FAIL err_cnt got=%0d exp=4", outst_cnt); end
        @(negedge clk);
        rel_valid = 1'b1; rel_tid = 4'd0;
        @(negedge clk);
        rel_valid = 1'b0;
        #1;
        checks++; if (outst_cnt !== 5'd3) begin errors++; $display("FAIL err_valid_rel_cnt got=%0d exp=3", outst_cnt); end
        checks++; if (err !== 1'b1)       begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky2 got=%b exp=1", err); end
        // After reset the old TIDs are forgotten, so releasing one is invalid
        test_mid_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_rst_clr got=%b exp=0", err); end
        @(negedge clk);
        rel_valid = 1'b1; rel_tid = 4'd1;
        @(negedge clk);
        rel_valid = 1'b0;
        #1;
        checks++; if (err !== 1'b1)       begin errors++; $display("FAIL err_post_rst got=%b exp=1", err); end
        checks++; if (outst_cnt !== 5'd0) begin errors++; $display("FAIL err_post_rst_cnt got=%0d exp=0", outst_cnt); end
    endtask

    task automatic test_max4();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alloc_req4 = 1'b1;
            #1;
            checks++; if (alloc_gnt4 !== 1'b1) begin errors++; $display("FAIL m4_gnt[%0d] got=%b exp=1", i, alloc_gnt4); end
            checks++; if (tid4 !== 4'(i))      begin errors++; $display("FAIL m4_tid[%0d] got=%0d exp=%0d", i, tid4, i); end
        end
        @(negedge clk);
        #1;
        checks++; if (outst_cnt4 !== 5'd4) begin errors++; $display("FAIL m4_cnt got=%0d exp=4", outst_cnt4); end
        checks++; if (full4 !== 1'b1)      begin errors++; $display("FAIL m4_full got=%b exp=1", full4); end
        checks++; if (alloc_gnt4 !== 1'b0) begin errors++; $display("FAIL m4_deny got=%b exp=0", alloc_gnt4); end
        checks++; if (tid_valid4 !== 1'b0) begin errors++; $display("FAIL m4_tvalid got=%b exp=0", tid_valid4); end
        checks++; if (tid4 !== 4'd4)       begin errors++; $display("FAIL m4_cand got=%0d exp=4", tid4); end
        @(negedge clk);
        #1;
        checks++; if (outst_cnt4 !== 5'd4) begin errors++; $display("FAIL m4_hold got=%0d exp=4", outst_cnt4); end
        alloc_req4 = 1'b0;
    endtask

`ifdef EXT_TID_ROUND_ROBIN_EN
    task automatic test_round_robin();
        test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            alloc_req = 1'b1;
            #1;
            checks++; if (tid !== 4'(i)) begin errors++; $display("FAIL rr_tid[%0d] got=%0d exp=%0d", i, tid, i); end
        end
        @(negedge clk);
        alloc_req = 1'b0; rel_valid = 1'b1; rel_tid = 4'd0;
        @(negedge clk);
        rel_valid = 1'b0; alloc_req = 1'b1;
        #1;
        checks++; if (tid !== 4'd2) begin errors++; $display("FAIL rr_skip got=%0d exp=2", tid); end
        for (int i = 3; i < 16; i++) begin
            @(negedge clk);
            #1;
            checks++; if (tid !== 4'(i)) begin errors++; $display("FAIL rr_walk[%0d] got=%0d exp=%0d", i, tid, i); end
        end
        @(negedge clk);
        #1;
        checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL rr_wrap_gnt got=%b exp=1", alloc_gnt); end
        checks++; if (tid !== 4'd0)       begin errors++; $display("FAIL rr_wrap_tid got=%0d exp=0", tid); end
        @(negedge clk);
        alloc_req = 1'b0;
        test_mid_reset();
        alloc_req = 1'b1;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rr_rst_idle got=%b exp=1", idle); end
        checks++; if (tid !== 4'd0)  begin errors++; $display("FAIL rr_rst_tid got=%0d exp=0", tid); end
        @(negedge clk);
        alloc_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_release_from_full();
        test_mid_reset();
        test_same_cycle();
        test_err();
        test_max4();
`ifdef EXT_TID_ROUND_ROBIN_EN
        test_round_robin();
`endif
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
